gh_baud_rate_gen_frac: RTL

Parametrised fractional baud-rate generator, the successor to the 16-bit integer generator in the UART core. It has a programmable integer divisor of DIV_W bits and a fractional divisor of FRAC_W bits. Average tick period is INT + FRAC/2^FRAC_W clocks, which cuts baud error at high rates. Runs on the single system clock with an enable input, byte-enabled register writes and readback; it feeds the UART TX/RX oversampling logic.

---
 rtl/gh_baud_rate_gen_frac.sv | 88 ++++++++
 1 files changed

// File: rtl/gh_baud_rate_gen_frac.sv
// rtl/gh_baud_rate_gen_frac.sv - fractional baud-rate generator with byte-enabled divisor registers
module gh_baud_rate_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WR,
  input  logic               ADDR,
  input  logic [DIV_W/8-1:0] BE,
  input  logic [DIV_W-1:0]   D,
  input  logic               EN,
  output logic [DIV_W-1:0]   RD,
  output logic               rCE,
  output logic               rCLK
);

  localparam int NB = DIV_W / 8;
  localparam logic [DIV_W:0] CNT_ZERO = '0;
  localparam logic [DIV_W:0] CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W-1:0]  rate_int;
  logic [FRAC_W-1:0] rate_frac;
  logic [DIV_W:0]    count;
  logic [FRAC_W-1:0] acc;
  logic              reload;

  logic              active;
  logic              terminal;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    next_load;
  logic [DIV_W:0]    half_rate;

  assign active    = (rate_int != '0);
  assign terminal  = (count == CNT_ONE) || (count == CNT_ZERO);
  assign acc_sum   = {1'b0, acc} + {1'b0, rate_frac};
  // Carry out of the fraction accumulator stretches this period by one clock.
  assign next_load = {1'b0, rate_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
  assign half_rate = {1'b0, rate_int >> 1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_int  <= '0;
      rate_frac <= '0;
      reload    <= 1'b0;
    end else begin
      reload <= WR && (BE != '0);
      if (WR) begin
        if (!ADDR) begin
          for (int i = 0; i < NB; i++) begin
            if (BE[i]) rate_int[8*i +: 8] <= D[8*i +: 8];
          end
        end else if (BE[0]) begin
          rate_frac <= D[FRAC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
      rCLK  <= 1'b0;
    end else if (!active) begin
      count <= '0;
      acc   <= '0;
      rCLK  <= 1'b0;
    end else begin
      if (EN) rCLK <= (count > half_rate);
      if (reload) begin
        count <= {1'b0, rate_int};
        acc   <= '0;
      end else if (EN) begin
        if (terminal) begin
          count <= next_load;
          acc   <= acc_sum[FRAC_W-1:0];
        end else begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  assign rCE = active && EN && (count == CNT_ONE);
  assign RD  = ADDR ? {{(DIV_W-FRAC_W){1'b0}}, rate_frac} : rate_int;

endmodule
